// File: rtl/buffered_join_pkg.sv
// Shared handshake package: constants and helpers used by the join and its
// per-channel token counters.
package buffered_join_pkg;

  // Legal parameter ranges for the join.
  localparam int MIN_SIZE  = 2;
  localparam int MAX_SIZE  = 16;
  localparam int MIN_DEPTH = 1;
  localparam int MAX_DEPTH = 15;

  // Ceiling log2 for elaboration-time width calculation.
  // The result is never less than 1, so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/buffered_join_token_counter.sv
// Per-channel token occupancy counter (0..DEPTH).
// The parent only asserts push when a slot is free, or when a pop frees one
// in the same cycle, so the count can never go past DEPTH. The parent only
// asserts pop when every channel is nonempty, so the count can never drop
// below zero. Push and pop together leave the count unchanged.
module token_counter
  import buffered_join_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  output logic full,
  output logic nonempty
);

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] FULL_VAL = CW'(DEPTH);

  logic [CW-1:0] cnt;

  // Occupancy update: +1 on push only, -1 on pop only, hold otherwise; async clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (push && !pop) begin
      cnt <= cnt + ONE;
    end else if (pop && !push) begin
      cnt <= cnt - ONE;
    end
  end

  assign full     = (cnt == FULL_VAL);
  assign nonempty = (cnt != '0);

endmodule

// File: rtl/buffered_join.sv
// Buffered join: SIZE input channels, each buffering up to DEPTH tokens,
// joined into one output token.
//
// Handshake: a transfer happens on any cycle where valid and ready are both
// 1 at the rising clock edge. outs_valid comes only from registered
// occupancy, and once it is raised it stays high until the transfer happens.
// ins_ready never looks at ins_valid. It looks at outs_ready only when a
// channel is full, where a pop in the same cycle frees the slot that the new
// token will take.
module buffered_join
  import buffered_join_pkg::*;
#(
  parameter int SIZE  = 2,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] ins_valid,
  output logic [SIZE-1:0] ins_ready,
  output logic            outs_valid,
  input  logic            outs_ready
);

  localparam int CW = clog2(DEPTH + 1);

  logic [SIZE-1:0] full;
  logic [SIZE-1:0] nonempty;
  logic [SIZE-1:0] push;
  logic            pop;

  // A joined token exists only when every channel holds at least one token.
  assign outs_valid = &nonempty;

  // One output transfer consumes one token from every channel.
  assign pop = outs_valid & outs_ready;

  // Accept while there is room, or when the same-cycle pop makes room.
  assign ins_ready = ~full | {SIZE{pop}};

  assign push = ins_valid & ins_ready;

  for (genvar i = 0; i < SIZE; i++) begin : g_chan
    token_counter #(
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .push     (push[i]),
      .pop      (pop),
      .full     (full[i]),
      .nonempty (nonempty[i])
    );
  end

endmodule

// File: tb/tb_buffered_join.sv
// Self-checking bench for buffered_join: directed table on a 2x2 join, plus
// hand sequences for reset, the full-with-pop case, streaming, and a
// scoreboarded random run.
module tb_buffered_join;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT A: SIZE=3 DEPTH=2 ; DUT B: SIZE=2 DEPTH=2 ; DUT C: SIZE=2 DEPTH=1 ; DUT D: SIZE=4 DEPTH=1
  logic [2:0] va, ra;
  logic       ova, or_a;
  logic [1:0] vb, rb;
  logic       ovb, or_b;
  logic [1:0] vc, rc;
  logic       ovc, or_c;
  logic [3:0] vd, rd;
  logic       ovd, or_d;

  buffered_join #(.SIZE(3), .DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .ins_valid(va), .ins_ready(ra), .outs_valid(ova), .outs_ready(or_a));
  buffered_join #(.SIZE(2), .DEPTH(2)) u_b (
    .clk(clk), .rst(rst), .ins_valid(vb), .ins_ready(rb), .outs_valid(ovb), .outs_ready(or_b));
  buffered_join #(.SIZE(2), .DEPTH(1)) u_c (
    .clk(clk), .rst(rst), .ins_valid(vc), .ins_ready(rc), .outs_valid(ovc), .outs_ready(or_c));
  buffered_join #(.SIZE(4), .DEPTH(1)) u_d (
    .clk(clk), .rst(rst), .ins_valid(vd), .ins_ready(rd), .outs_valid(ovd), .outs_ready(or_d));

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst  = 1'b0;
    va   = '0; or_a = 1'b0;
    vb   = '0; or_b = 1'b0;
    vc   = '0; or_c = 1'b0;
    vd   = '0; or_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- directed table (DUT B) ----------------
  typedef struct {
    logic [1:0] v;
    logic       oready;
    logic [1:0] exp_ready;
    logic       exp_ov;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];

  // ---------------- scoreboard (random run on DUT A) ----------------
  logic [15:0] exp_q[$];
  int mcnt   [3];
  int in_tot [3];
  int joined;
  int seq_out;
  int m_out;
  int n_out;
  int n_in [4];
  int min_in;
  int drain_pops;
  int drain_left;
  logic [2:0] m_ready;
  logic       m_ov;
  logic       m_pop;
  logic       prev_hold;
  logic [15:0] front;

  initial begin
    // Skewed arrival: ch0 at row 0, ch1 at row 3, one output at row 4.
    tbl[0]  = '{2'b01, 1'b1, 2'b11, 1'b0};
    tbl[1]  = '{2'b00, 1'b1, 2'b11, 1'b0};
    tbl[2]  = '{2'b00, 1'b1, 2'b11, 1'b0};
    tbl[3]  = '{2'b10, 1'b1, 2'b11, 1'b0};
    tbl[4]  = '{2'b00, 1'b1, 2'b11, 1'b1};
    tbl[5]  = '{2'b00, 1'b1, 2'b11, 1'b0};
    // Fill ch0 under backpressure: two accepts, then ready[0] drops.
    tbl[6]  = '{2'b01, 1'b0, 2'b11, 1'b0};
    tbl[7]  = '{2'b01, 1'b0, 2'b11, 1'b0};
    tbl[8]  = '{2'b01, 1'b0, 2'b10, 1'b0};
    tbl[9]  = '{2'b01, 1'b0, 2'b10, 1'b0};
    // ch1 arrives; full ch0 only reopens with a same-cycle pop.
    tbl[10] = '{2'b10, 1'b0, 2'b10, 1'b0};
    tbl[11] = '{2'b00, 1'b0, 2'b10, 1'b1};
    tbl[12] = '{2'b11, 1'b1, 2'b11, 1'b1};
    tbl[13] = '{2'b00, 1'b0, 2'b10, 1'b1};
    tbl[14] = '{2'b00, 1'b1, 2'b11, 1'b1};
    tbl[15] = '{2'b00, 1'b1, 2'b11, 1'b0};
    // Fill both to DEPTH, then drain two joined tokens.
    tbl[16] = '{2'b10, 1'b1, 2'b11, 1'b0};
    tbl[17] = '{2'b11, 1'b0, 2'b11, 1'b1};
    tbl[18] = '{2'b11, 1'b0, 2'b00, 1'b1};
    tbl[19] = '{2'b00, 1'b1, 2'b11, 1'b1};
    tbl[20] = '{2'b00, 1'b1, 2'b11, 1'b1};
    tbl[21] = '{2'b00, 1'b1, 2'b11, 1'b0};

    // ---- reset state, held asynchronously ----
    rst = 1'b0;
    va = '0; vb = '0; vc = '0; vd = '0;
    or_a = 1'b0; or_b = 1'b0; or_c = 1'b0; or_d = 1'b0;
    #2;
    check("rst_ready_a", int'(ra), 7);
    check("rst_ov_a", int'(ova), 0);
    check("rst_ready_d", int'(rd), 15);
    check("rst_ov_d", int'(ovd), 0);

    // ---- table vectors on DUT B ----
    reset_all();
    for (int i = 0; i < NVEC; i++) begin
      vb   = tbl[i].v;
      or_b = tbl[i].oready;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", i), int'(rb), int'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_ov", i), int'(ovb), int'(tbl[i].exp_ov));
      next_cycle();
    end

    // ---- mid-stream async reset on DUT A with cnt={2,1,0} ----
    reset_all();
    va = 3'b011; or_a = 1'b0;
    next_cycle();
    va = 3'b001;
    next_cycle();
    va = 3'b000;
    @(negedge clk);
    check("pre_rst_ready", int'(ra), 3'b110);
    check("pre_rst_ov", int'(ova), 0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_ready", int'(ra), 7);
    check("async_rst_ov", int'(ova), 0);
    // Inputs offered during reset must not be counted.
    va = 3'b111;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    va  = 3'b000;
    @(negedge clk);
    check("post_rst_ov", int'(ova), 0);
    check("post_rst_ready", int'(ra), 7);
    next_cycle();
    // Only ch2 gets a token: a stale ch0/ch1 token would complete the join.
    va = 3'b100; or_a = 1'b1;
    next_cycle();
    va = 3'b000;
    @(negedge clk);
    check("no_stale_ov", int'(ova), 0);
    next_cycle();
    va = 3'b011;
    next_cycle();
    va = 3'b000;
    @(negedge clk);
    check("join_after_rst_ov", int'(ova), 1);
    next_cycle();
    @(negedge clk);
    check("single_output_ov", int'(ova), 0);
    next_cycle();

    // ---- DEPTH=1 full with simultaneous pop (DUT C) ----
    reset_all();
    vc = 2'b11; or_c = 1'b0;
    @(negedge clk);
    check("c_empty_ready", int'(rc), 3);
    check("c_empty_ov", int'(ovc), 0);
    next_cycle();
    @(negedge clk);
    check("c_full_ready", int'(rc), 0);
    check("c_full_ov", int'(ovc), 1);
    or_c = 1'b1;
    #1;
    check("c_full_pop_ready", int'(rc), 3);
    next_cycle();
    @(negedge clk);
    check("c_after_pop_ov", int'(ovc), 1);
    or_c = 1'b0;
    #1;
    check("c_after_pop_ready", int'(rc), 0);
    vc = 2'b00; or_c = 1'b1;
    next_cycle();
    @(negedge clk);
    check("c_drained_ov", int'(ovc), 0);
    next_cycle();

    // ---- streaming, SIZE=4 DEPTH=1, 100 cycles (DUT D) ----
    reset_all();
    vd = 4'hf; or_d = 1'b1;
    n_out = 0;
    for (int ch = 0; ch < 4; ch++) n_in[ch] = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (ovd && or_d) n_out++;
      for (int ch = 0; ch < 4; ch++) begin
        if (vd[ch] && rd[ch]) n_in[ch]++;
      end
      next_cycle();
    end
    vd = 4'h0; or_d = 1'b0;
    @(negedge clk);
    check("stream_outputs", n_out, 99);
    check("stream_final_ov", int'(ovd), 1);
    for (int ch = 0; ch < 4; ch++) begin
      check($sformatf("stream_in_ch%0d", ch), n_in[ch], n_out + 1);
    end
    next_cycle();

    // ---- random stimulus with scoreboard (DUT A) ----
    reset_all();
    exp_q.delete();
    for (int ch = 0; ch < 3; ch++) begin
      mcnt[ch]   = 0;
      in_tot[ch] = 0;
    end
    joined    = 0;
    seq_out   = 0;
    m_out     = 0;
    prev_hold = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      va   = 3'($urandom_range(0, 7));
      or_a = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      m_ov = (mcnt[0] > 0) && (mcnt[1] > 0) && (mcnt[2] > 0);
      m_pop = m_ov && or_a;
      for (int ch = 0; ch < 3; ch++) begin
        m_ready[ch] = (mcnt[ch] < 2) || m_pop;
      end
      check($sformatf("rand%0d_ready", cyc), int'(ra), int'(m_ready));
      check($sformatf("rand%0d_ov", cyc), int'(ova), int'(m_ov));
      if (prev_hold) check($sformatf("rand%0d_persist", cyc), int'(ova), 1);
      if (ova && or_a) begin
        if (exp_q.size() == 0) begin
          check($sformatf("rand%0d_sb_empty", cyc), 1, 0);
        end else begin
          front = exp_q.pop_front();
          check($sformatf("rand%0d_sb_token", cyc), seq_out, int'(front));
        end
        seq_out++;
      end
      if (m_pop) m_out++;
      for (int ch = 0; ch < 3; ch++) begin
        if (va[ch] && m_ready[ch]) begin
          in_tot[ch]++;
          if (!m_pop) mcnt[ch]++;
        end else if (m_pop) begin
          mcnt[ch]--;
        end
      end
      min_in = in_tot[0];
      for (int ch = 1; ch < 3; ch++) if (in_tot[ch] < min_in) min_in = in_tot[ch];
      while (joined < min_in) begin
        exp_q.push_back(16'(joined));
        joined++;
      end
      prev_hold = ova && !or_a;
      next_cycle();
    end
    check("rand_out_count", seq_out, m_out);
    // Drain: exactly the held joined tokens come out, within a bounded window.
    va = 3'b000; or_a = 1'b1;
    drain_pops = 0;
    drain_left = exp_q.size();
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (ova) drain_pops++;
      next_cycle();
    end
    check("rand_drain_pops", drain_pops, drain_left);
    @(negedge clk);
    check("rand_drained_ov", int'(ova), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buffered_join.md
BUFFERED_JOIN -- requirements
Module: buffered_join

Interface
REQ-001 Parameter SIZE, default 2: number of input channels; legal range 2..16.
REQ-002 Parameter DEPTH, default 2: tokens each input channel can hold; legal range 1..15.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low (0 = reset).
REQ-005 ins_valid  input  SIZE  per-channel token offered.
REQ-006 ins_ready  output  SIZE  per-channel token accepted this cycle.
REQ-007 outs_valid  output  1  joined token available.
REQ-008 outs_ready  input  1  consumer accepts the joined token.

Function
REQ-009 The block SHALL keep one token counter cnt[i] per channel, CW = clog2(DEPTH+1) bits wide, range 0..DEPTH.
REQ-010 ins_ready[i] SHALL be 1 exactly when cnt[i] < DEPTH, or when cnt[i] == DEPTH and outs_valid & outs_ready are both 1 (pop frees a slot the same cycle).
REQ-011 ins_ready SHALL NOT depend on any ins_valid bit; it may depend on outs_ready only through the REQ-010 full case.
REQ-012 outs_valid SHALL be 1 exactly when every cnt[i] > 0; it is a function of registered state only.
REQ-013 Input transfer on channel i: ins_valid[i] & ins_ready[i]. Output transfer: outs_valid & outs_ready.
REQ-014 Per cycle, per channel: input transfer without output transfer -> cnt[i]+1; output transfer without input transfer -> cnt[i]-1; both or neither -> unchanged.
REQ-015 An output transfer SHALL decrement every channel's counter in the same cycle.
REQ-016 Latency: a token accepted on the last-filled channel in cycle N SHALL produce outs_valid = 1 in cycle N+1. There is no combinational bypass.
REQ-017 Throughput: with all inputs valid and outs_ready held at 1, the block SHALL sustain one output transfer per cycle after the first, for any DEPTH >= 1.
REQ-018 The counters SHALL never exceed DEPTH or fall below 0. Counters saturate by construction; they do not wrap.
REQ-019 A channel with an early token SHALL hold it, keep accepting until full, and not lose or duplicate tokens while other channels are empty.
REQ-020 Once outs_valid is 1, it SHALL remain 1 until an output transfer occurs (AXI-style persistence).

Reset
REQ-021 While rst = 0: all cnt[i] = 0, outs_valid = 0, and ins_ready = all ones, asynchronously.
REQ-022 Reset asserted mid-operation SHALL discard all held tokens. Operation resumes on the first rising clk edge after rst returns to 1.
REQ-023 No input transfer SHALL be counted on the clock edge at which rst = 0.

Structure
REQ-024 Counter-width constant function clog2 SHALL live in the shared handshake package; no typedefs are needed.
REQ-025 One sub-module, token_counter (parameters DEPTH and CW), SHALL be instantiated SIZE times.
REQ-026 token_counter SHALL have these ports: clk, rst, push, pop, full, nonempty.
REQ-027 The top level SHALL contain only the SIZE-wide AND reduction, the pop fan-out, and the ready gating.

Verification
REQ-028 Reset: SIZE=3, DEPTH=2, rst=0 asynchronously mid-stream with cnt={2,1,0} -> immediately outs_valid=0 and ins_ready=3'b111; after release, no stale token appears.
REQ-029 Skewed arrival: SIZE=2, DEPTH=2; ch0 valid at cycle 1, ch1 valid at cycle 4, outs_ready=1 -> exactly one output transfer at cycle 5; ins_ready[0] stays 1.
REQ-030 Fill/backpressure: SIZE=2, DEPTH=2, ch0 valid every cycle, ch1 idle, outs_ready=0 -> ch0 accepts 2 tokens, then ins_ready[0]=0; outs_valid stays 0.
REQ-031 Full with simultaneous pop: DEPTH=1, both counters 1, outs_ready=1, both valid -> ins_ready=2'b11, output transfer and input transfers in the same cycle, counters stay 1.
REQ-032 Streaming: SIZE=4, DEPTH=1, all valid, outs_ready=1 for 100 cycles -> 99 output transfers; per-channel input count = output count + final cnt.
REQ-033 Random stimulus with a scoreboard -> tokens out = min over channels of tokens in, minus tokens held; outs_valid never drops without a transfer; cnt never exceeds DEPTH.
